// File: rtl/qa_driver_csr_pkg.sv
// Shared CSR-path types: SREG data/address, the SREG bridge FSM encoding and
// the default data returned when a LEAP SREG read times out.
package qa_driver_csr_pkg;

  typedef logic [63:0] t_sreg;
  typedef logic [31:0] t_sreg_addr;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RSP
  } t_sreg_bridge_state;

  localparam t_sreg SREG_TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/qa_driver_timeout_ctr.sv
// Saturating timeout counter: clear wins over enable, and the count parks at
// CYCLES-1 so that expired stays asserted instead of wrapping.
module qa_driver_timeout_ctr #(
  parameter int CYCLES = 4096,
  localparam int W     = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt_q <= '0;
    else if (clear)              cnt_q <= '0;
    else if (enable && !expired) cnt_q <= cnt_q + 1'b1;
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/qa_driver_sreg_bridge.sv
// Bridges one-cycle CSR SREG read triggers onto the LEAP valid/ready request
// channel; a timeout forces exactly one response per accepted trigger.
module qa_driver_sreg_bridge
  import qa_driver_csr_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [63:0] TIMEOUT_DATA   = SREG_TIMEOUT_DATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] sreg_addr,
  input  logic        sreg_req_rdy,
  output logic [63:0] sreg_rsp,
  output logic        sreg_rsp_enable,
  output logic        leap_req_valid,
  output logic [31:0] leap_req_addr,
  input  logic        leap_req_ready,
  input  logic        leap_rsp_valid,
  input  logic [63:0] leap_rsp_data,
  input  logic        err_clear,
  output logic        err_timeout,
  output logic        err_overlap
);

  t_sreg_bridge_state state_q, state_d;
  logic       stale_q, stale_d;
  logic       pend_q, pend_d;
  t_sreg_addr addr_d;
  t_sreg      rsp_d;
  logic       err_to_d, err_ov_d;
  logic       timer_clear, timer_en, timer_expired;

  logic in_idle, accept, launch_pend, defer, overlap, rsp_take, to_req, to_wait;

  assign in_idle     = (state_q == S_IDLE);
  assign accept      = in_idle && sreg_req_rdy && !stale_q && !pend_q;
  assign defer       = in_idle && sreg_req_rdy &&  stale_q && !pend_q;
  assign launch_pend = in_idle && pend_q && !stale_q;
  assign overlap     = sreg_req_rdy && (!in_idle || pend_q);
  assign rsp_take    = (state_q == S_WAIT) && leap_rsp_valid && !stale_q;
  assign to_req      = (state_q == S_REQ) && timer_expired;
  assign to_wait     = (state_q == S_WAIT) && timer_expired && !rsp_take;

  assign timer_clear = in_idle;
  assign timer_en    = (state_q == S_REQ) || (state_q == S_WAIT);

  qa_driver_timeout_ctr #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Expiry beats a same-cycle ready in REQ so the response deadline holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept || launch_pend) state_d = S_REQ;
      S_REQ:  if (timer_expired)         state_d = S_RSP;
              else if (leap_req_ready)   state_d = S_WAIT;
      S_WAIT: if (rsp_take || timer_expired) state_d = S_RSP;
      S_RSP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A request LEAP accepted but we abandoned still owes a response: mark it stale.
  always_comb begin
    stale_d  = (stale_q && !leap_rsp_valid) || to_wait || (to_req && leap_req_ready);
    pend_d   = (pend_q && !launch_pend) || defer;
    addr_d   = (accept || defer) ? sreg_addr : leap_req_addr;
    rsp_d    = sreg_rsp;
    if (rsp_take)                rsp_d = leap_rsp_data;
    else if (to_req || to_wait)  rsp_d = TIMEOUT_DATA;
    err_to_d = to_req || to_wait || (err_timeout && !err_clear);
    err_ov_d = overlap || (err_overlap && !err_clear);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stale_q         <= 1'b0;
      pend_q          <= 1'b0;
      leap_req_addr   <= '0;
      leap_req_valid  <= 1'b0;
      sreg_rsp        <= '0;
      sreg_rsp_enable <= 1'b0;
      err_timeout     <= 1'b0;
      err_overlap     <= 1'b0;
    end else begin
      stale_q         <= stale_d;
      pend_q          <= pend_d;
      leap_req_addr   <= addr_d;
      leap_req_valid  <= (state_d == S_REQ);
      sreg_rsp        <= rsp_d;
      sreg_rsp_enable <= (state_d == S_RSP);
      err_timeout     <= err_to_d;
      err_overlap     <= err_ov_d;
    end
  end

endmodule

// File: tb/tb_qa_driver_sreg_bridge.sv
// Scoreboard bench: stimulus predicts each read's outcome from LEAP delays,
// a reactive LEAP model serves requests, a monitor checks every response pulse.
module tb_qa_driver_sreg_bridge;

  localparam int          TC      = 8;
  localparam logic [63:0] TO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int          NEVER   = 1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] sreg_addr = '0;
  logic        sreg_req_rdy = 1'b0;
  logic [63:0] sreg_rsp;
  logic        sreg_rsp_enable;
  logic        leap_req_valid;
  logic [31:0] leap_req_addr;
  logic        leap_req_ready = 1'b0;
  logic        leap_rsp_valid = 1'b0;
  logic [63:0] leap_rsp_data = '0;
  logic        err_clear = 1'b0;
  logic        err_timeout;
  logic        err_overlap;

  always #5 clk = ~clk;

  qa_driver_sreg_bridge #(.TIMEOUT_CYCLES(TC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sreg_addr       (sreg_addr),
    .sreg_req_rdy    (sreg_req_rdy),
    .sreg_rsp        (sreg_rsp),
    .sreg_rsp_enable (sreg_rsp_enable),
    .leap_req_valid  (leap_req_valid),
    .leap_req_addr   (leap_req_addr),
    .leap_req_ready  (leap_req_ready),
    .leap_rsp_valid  (leap_rsp_valid),
    .leap_rsp_data   (leap_rsp_data),
    .err_clear       (err_clear),
    .err_timeout     (err_timeout),
    .err_overlap     (err_overlap)
  );

  typedef struct { int dr; int ds; logic [63:0] data; logic [31:0] addr; } cfg_t;
  typedef struct { logic [63:0] data; bit timeout; } exp_t;

  cfg_t cfg_q[$];
  exp_t sb_q[$];
  int   tests = 0, fails = 0, pulses = 0;
  bit   exp_err_to = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request seen at E: handshake at E+dr, response at E+1+dr+ds; last
  // cycle a response counts is E+TC-1.
  function automatic exp_t predict(cfg_t c);
    exp_t e;
    e.timeout = (c.dr + c.ds + 2 > TC);
    e.data    = e.timeout ? TO_DATA : c.data;
    return e;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && sreg_rsp_enable) begin
        pulses++;
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pulse: got rsp %h with no read outstanding at %0t", sreg_rsp, $time);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_data", sreg_rsp, e.data);
          if (e.timeout) exp_err_to = 1'b1;
          chk("err_timeout_at_rsp", err_timeout, exp_err_to);
        end
      end
    end
  end

  // LEAP model
  initial begin
    cfg_t cur;
    bit   have = 1'b0;
    int   wcnt = 0, rsp_cnt = 0;
    logic [63:0] rsp_data = '0;
    forever begin
      @(negedge clk);
      leap_req_ready = 1'b0;
      leap_rsp_valid = 1'b0;
      if (!reset_n) begin
        have = 1'b0; rsp_cnt = 0;
      end else begin
        if (rsp_cnt > 0) begin
          chk("no_req_while_rsp_owed", leap_req_valid, 1'b0);
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            leap_rsp_valid = 1'b1;
            leap_rsp_data  = rsp_data;
          end
        end
        if (leap_req_valid) begin
          if (!have) begin
            if (cfg_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL spurious_req: got req addr %h with none expected at %0t", leap_req_addr, $time);
            end else begin
              cur = cfg_q.pop_front(); have = 1'b1; wcnt = 0;
            end
          end
          if (have) begin
            chk("req_addr", leap_req_addr, cur.addr);
            if (wcnt == cur.dr) begin
              leap_req_ready = 1'b1;
              rsp_cnt  = cur.ds + 1;
              rsp_data = cur.data;
              have = 1'b0;
            end else wcnt++;
          end
        end else have = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic trigger(cfg_t c);
    sreg_addr    = c.addr;
    sreg_req_rdy = 1'b1;
    cfg_q.push_back(c);
    sb_q.push_back(predict(c));
    @(negedge clk);
    sreg_req_rdy = 1'b0;
  endtask

  task automatic wait_pulse(int limit);
    int n = 0;
    while (!sreg_rsp_enable && n < limit) begin @(negedge clk); n++; end
    if (!sreg_rsp_enable) begin
      tests++; fails++;
      $display("FAIL rsp_wait: got no sreg_rsp_enable within %0d cycles, required one", limit);
    end
    @(negedge clk);
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    exp_err_to = 1'b0;
    chk("err_timeout_cleared", err_timeout, 1'b0);
    chk("err_overlap_cleared", err_overlap, 1'b0);
  endtask

  task automatic basic_read();
    trigger('{dr:0, ds:0, data:64'h1234, addr:32'h10});
    chk("basic_valid_t1", leap_req_valid, 1'b1);
    chk("basic_addr_t1", leap_req_addr, 32'h10);
    @(negedge clk);
    chk("basic_valid_t2", leap_req_valid, 1'b0);
    chk("basic_en_t2", sreg_rsp_enable, 1'b0);
    @(negedge clk);
    chk("basic_en_t3", sreg_rsp_enable, 1'b1);
    chk("basic_rsp_t3", sreg_rsp, 64'h1234);
    @(negedge clk);
    chk("basic_en_t4", sreg_rsp_enable, 1'b0);
  endtask

  initial begin
    cfg_t c;
    int   n, snap;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", leap_req_valid, 1'b0);
    chk("rst_req_addr", leap_req_addr, 32'h0);
    chk("rst_rsp", sreg_rsp, 64'h0);
    chk("rst_rsp_en", sreg_rsp_enable, 1'b0);
    chk("rst_err_to", err_timeout, 1'b0);
    chk("rst_err_ov", err_overlap, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    basic_read();

    // Backpressure: ready low for 5 cycles, valid/address must hold.
    trigger('{dr:5, ds:0, data:64'hA5A5_0001, addr:32'h0000_BEEF});
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", leap_req_valid, 1'b1);
      chk("bp_addr_held", leap_req_addr, 32'h0000_BEEF);
      @(negedge clk);
    end
    wait_pulse(20);

    // Ready never comes: REQ timeout, pulse at T+TC+1.
    trigger('{dr:NEVER, ds:0, data:64'h1, addr:32'h44});
    n = 1;
    while (!sreg_rsp_enable && n < 50) begin @(negedge clk); n++; end
    chk("req_timeout_latency", n, TC + 1);
    @(negedge clk);
    clear_errs();

    // Boundary: response on the expiry cycle wins; one cycle later times out.
    trigger('{dr:0, ds:TC-2, data:64'hB0B0, addr:32'h50});
    wait_pulse(30);
    chk("edge_no_err", err_timeout, 1'b0);
    trigger('{dr:0, ds:TC-1, data:64'hB1B1, addr:32'h54});
    wait_pulse(30);
    repeat (3) @(negedge clk);
    clear_errs();

    // WAIT timeout with late response, then a deferred trigger.
    trigger('{dr:0, ds:10, data:64'hCAFE_0000, addr:32'h60});
    wait_pulse(30);
    trigger('{dr:0, ds:1, data:64'hF00D_F00D, addr:32'h64});
    chk("deferred_req_low", leap_req_valid, 1'b0);
    wait_pulse(40);
    chk("err_timeout_sticky", err_timeout, 1'b1);
    clear_errs();

    // Overlap: second trigger while in WAIT.
    trigger('{dr:0, ds:4, data:64'h0BAD_0001, addr:32'h70});
    @(negedge clk);
    sreg_addr = 32'h74; sreg_req_rdy = 1'b1;
    @(negedge clk);
    sreg_req_rdy = 1'b0;
    wait_pulse(20);
    chk("overlap_flag", err_overlap, 1'b1);
    repeat (5) @(negedge clk);
    clear_errs();

    // Reset in WAIT: immediate reset values, no pulse, then a normal read.
    trigger('{dr:0, ds:5, data:64'h7777, addr:32'h80});
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", leap_req_valid, 1'b0);
    chk("midrst_addr", leap_req_addr, 32'h0);
    chk("midrst_rsp", sreg_rsp, 64'h0);
    chk("midrst_en", sreg_rsp_enable, 1'b0);
    sb_q.delete(); cfg_q.delete();
    exp_err_to = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    snap = pulses;
    repeat (10) @(negedge clk);
    chk("midrst_no_pulse", pulses, snap);
    basic_read();

    // Randomised back-to-back reads.
    for (int k = 0; k < 40; k++) begin
      c.dr   = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, TC - 2);
      c.ds   = $urandom_range(0, 9);
      c.data = {$urandom, $urandom};
      c.addr = $urandom;
      trigger(c);
      wait_pulse(60);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) clear_errs();
    end

    repeat (20) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, required finish", $time);
    $fatal(1);
  end

endmodule
